// File: rtl/piso_stream_shifter_pkg.sv
// Shared definitions for the bit-serial stream blocks: FSM state encoding,
// stream-direction constants and a constant-foldable clog2.
package coa_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/piso_stream_shifter_if.sv
// Load-side and bit-side handshake bundle of the parallel-in/serial-out shifter.
interface piso_stream_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int CNT_W = coa_serial_pkg::clog2(WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_lsb_first;
  logic             abort;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_last;
  logic [CNT_W-1:0] bit_index;
  logic             busy;

  modport master (
    output load_valid, load_data, load_lsb_first, abort, bit_ready,
    input  load_ready, bit_valid, bit_out, bit_last, bit_index, busy
  );

  modport slave (
    input  load_valid, load_data, load_lsb_first, abort, bit_ready,
    output load_ready, bit_valid, bit_out, bit_last, bit_index, busy
  );
endinterface

// File: rtl/piso_stream_shifter_bit_index_counter.sv
// Ordinal of the bit currently presented; flags the final position WIDTH-1.
module bit_index_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/piso_stream_shifter.sv
// Parallel-in/serial-out shifter: loads a word, streams it MSB- or LSB-first
// under bit-side backpressure, and can reload in the same cycle as the last bit.
module piso_stream_shifter
  import coa_serial_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  piso_stream_shifter_if.slave  bus
);
  localparam int CNT_W = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             lsb_first_q, lsb_first_d;
  logic [CNT_W-1:0] idx;
  logic             term;
  logic             in_shift;
  logic             load_acc;
  logic             bit_acc;
  logic             last_acc;

  assign in_shift = (state_q == SHIFT);
  assign bit_acc  = in_shift & bus.bit_ready;
  assign last_acc = bit_acc & term;
  assign load_acc = bus.load_valid & bus.load_ready;

  // load_ready gated by reset so nothing is offered while the block is held.
  assign bus.load_ready = reset & ~bus.abort & (~in_shift | (term & bus.bit_ready));
  assign bus.bit_valid  = in_shift;
  assign bus.busy       = in_shift;
  assign bus.bit_last   = in_shift & term;
  assign bus.bit_index  = idx;
  assign bus.bit_out    = in_shift &
                          ((lsb_first_q == DIR_LSB_FIRST) ? data_q[0] : data_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (load_acc) state_d = SHIFT;
        SHIFT:   if (last_acc) state_d = load_acc ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d      = data_q;
    lsb_first_d = lsb_first_q;
    if (bus.abort) begin
      data_d = '0;
    end else if (load_acc) begin
      data_d      = bus.load_data;
      lsb_first_d = bus.load_lsb_first;
    end else if (bit_acc && !term) begin
      if (lsb_first_q == DIR_LSB_FIRST) begin
        data_d = {FILL_BIT, data_q[WIDTH-1:1]};
      end else begin
        data_d = {data_q[WIDTH-2:0], FILL_BIT};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      lsb_first_q <= DIR_MSB_FIRST;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      lsb_first_q <= lsb_first_d;
    end
  end

  // Index returns to 0 on every word boundary so IDLE always shows index 0.
  bit_index_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_index_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.abort | load_acc | last_acc),
    .en_i    (bit_acc & ~term),
    .count_o (idx),
    .term_o  (term)
  );
endmodule
